seg_scan_capture: RTL
=====================

// Module: seg_scan_capture
// PURPOSE
//  Receive-side counterpart of the 8-digit scanned 7-segment display driver.
//  Samples the multiplexed seg/ans bus, decodes each digit pattern back to a hex nibble, and reassembles the 32-bit word.
//  Used as an on-board loopback checker and as the bench monitor for the ALU-to-display path.
// PARAMETERS
//  SETTLE_CYC     4        cycles seg/ans must be unchanged before a digit is sampled (range 1..255)
//  TIMEOUT_CYC    200000   cycles with no digit captured before a partial frame is discarded
//  SEG_ACT_LOW    1        1: seg is active-low; 0: active-high
//  AN_ACT_LOW     1        1: ans is active-low; 0: active-high
// PORTS
//  clk        in   1   system clock, same clock as the display driver
//  reset      in   1   asynchronous, active-low reset
//  seg        in   7   segment bus {g,f,e,d,c,b,a}
//  ans        in   8   digit enables; ans[i] selects nibble i (value[4i+3:4i])
//  value      out  32  last completely captured word
//  value_vld  out  1   one-cycle pulse when value updates
//  frame_err  out  1   sticky: an undecodable pattern occurred in the current frame
//  stale      out  1   high after a timeout, until the next complete frame
// BEHAVIOUR
//  - Reset (async assert, sync release): value=0, value_vld=0, frame_err=0, stale=0; captured mask=0; FSM=S_IDLE.
//  - Inputs are normalised to active-high internally per the SEG_ACT_LOW and AN_ACT_LOW parameters, then registered once.
//  - FSM:
//    S_IDLE: ans not one-hot (all off or multiple on) -> stay; one-hot -> S_SETTLE, stable counter=1.
//    S_SETTLE: seg or ans differs from the previous cycle -> restart the counter (S_IDLE if not one-hot).
//      Counter reaches SETTLE_CYC -> sample, then S_HOLD.
//    S_HOLD: wait until ans changes -> S_IDLE or S_SETTLE. Each digit is sampled once per enable period.
//  - Sample: a valid hex pattern writes nibble[i] and sets captured[i]; a digit captured again overwrites its nibble.
//    An invalid pattern sets frame_err and leaves captured[i] unchanged.
//  - Frame complete: on the cycle captured becomes 8'hFF:
//      value <= assembled nibbles, registered, visible the next cycle together with value_vld=1 for one cycle.
//      captured <= 0; stale <= 0; frame_err clears on the same edge unless an error occurs in that cycle.
//  - Latency: last digit's ans edge -> value_vld = SETTLE_CYC + 2 cycles.
//  - Timeout: a counter resets on every sample; reaching TIMEOUT_CYC -> captured <= 0, stale <= 1, counter holds.
//    value is retained.
//  - Simultaneous events: frame complete and timeout in the same cycle -> completion wins.
//  - Reset mid-frame discards the partial frame; no value_vld is emitted.
//  - Decode, active-high {g..a}:
//      0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
//    7-bit blank (00) and all other codes are invalid.
// STRUCTURE
//  - Shared package: FSM state encoding (S_IDLE=2'd0, S_SETTLE=2'd1, S_HOLD=2'd2) and the 16 segment constants.
//    The display driver encodes from the same constants.
//  - One sub-module, seg7_to_hex: combinational {seg[6:0]} -> {ok, nib[3:0]}.
//  - Top level holds the FSM, settle/timeout counters, nibble registers and captured mask.
// TESTING
//  1. Drive the scan for 0x12345678 (ans active-low, 1000 cycles/digit) -> value_vld once, value=32'h12345678, frame_err=0.
//  2. Scan 0xDEADBEEF with 2-cycle glitches on seg at each digit change, SETTLE_CYC=4
//     -> value=32'hDEADBEEF, glitch patterns are never sampled.
//  3. Digit 3 shows pattern 7'h00 (blank), then the full correct frame 0x0000A5A5
//     -> frame_err=1 during the bad frame; value=32'h0000A5A5; frame_err=0 after completion.
//  4. Scan digits 0..4 only, then ans=8'hFF (all off) for TIMEOUT_CYC cycles
//     -> stale=1, no value_vld; the next full frame clears stale.
//  5. Assert reset after 6 digits of 0xCAFEF00D, release, then scan 0x00000001
//     -> outputs 0 during reset; a single value_vld with 32'h00000001.
//  6. Two digits enabled at once (ans=8'b11111100) for 50 cycles -> ignored; captured mask unchanged.

Source files
------------

// File: rtl/seg_scan_capture_pkg.sv
// Shared definitions for the scanned 7-segment capture path.
//   - state_t       : capture FSM state encoding
//   - SEG_x         : active-high {g,f,e,d,c,b,a} pattern for each hex digit
//   - hex_to_seg    : nibble -> pattern (encode side, same constants)
//   - is_onehot     : true when exactly one digit enable is active
//   - onehot_idx    : index of the active digit enable
package seg_scan_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    return pat;
  endfunction

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_scan_capture_if.sv
// Scanned display bus plus the capture results.
//   seg       [6:0]  segment bus {g..a}, polarity as driven on the board
//   ans       [7:0]  digit enables, polarity as driven on the board
//   value     [31:0] last completely captured word
//   value_vld        one-cycle pulse when value updates
//   frame_err        undecodable pattern seen in the current frame
//   stale            timeout occurred, cleared by the next complete frame
// master: display side (drives seg/ans, observes results)
// slave : capture block
interface seg_scan_capture_if;
  logic [6:0]  seg;
  logic [7:0]  ans;
  logic [31:0] value;
  logic        value_vld;
  logic        frame_err;
  logic        stale;

  modport master (
    output seg, ans,
    input  value, value_vld, frame_err, stale
  );

  modport slave (
    input  seg, ans,
    output value, value_vld, frame_err, stale
  );
endinterface

// File: rtl/seg7_to_hex.sv
// Combinational 7-segment pattern decoder.
//   i_seg [6:0] active-high {g..a}
//   o_ok        1 when i_seg is one of the 16 hex glyphs
//   o_nib [3:0] decoded nibble (0 when o_ok is low)
module seg7_to_hex
  import seg_scan_capture_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic       o_ok,
  output logic [3:0] o_nib
);

  always_comb begin
    o_ok  = 1'b1;
    o_nib = 4'h0;
    case (i_seg)
      SEG_0: o_nib = 4'h0;
      SEG_1: o_nib = 4'h1;
      SEG_2: o_nib = 4'h2;
      SEG_3: o_nib = 4'h3;
      SEG_4: o_nib = 4'h4;
      SEG_5: o_nib = 4'h5;
      SEG_6: o_nib = 4'h6;
      SEG_7: o_nib = 4'h7;
      SEG_8: o_nib = 4'h8;
      SEG_9: o_nib = 4'h9;
      SEG_A: o_nib = 4'hA;
      SEG_B: o_nib = 4'hB;
      SEG_C: o_nib = 4'hC;
      SEG_D: o_nib = 4'hD;
      SEG_E: o_nib = 4'hE;
      SEG_F: o_nib = 4'hF;
      default: o_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Receive side of the 8-digit scanned 7-segment display.
// Samples each digit once per enable period after the bus has been stable
// for SETTLE_CYC cycles, decodes it and reassembles the 32-bit word.
//   clk    system clock (same as the display driver)
//   reset  asynchronous assert, synchronous release, active low
//   bus    seg_scan_capture_if.slave (seg/ans in; value, value_vld,
//          frame_err, stale out)
module seg_scan_capture
  import seg_scan_capture_pkg::*;
#(
  parameter int unsigned SETTLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned SEG_ACT_LOW = 1,
  parameter int unsigned AN_ACT_LOW  = 1
) (
  input  logic                clk,
  input  logic                reset,
  seg_scan_capture_if.slave   bus
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  // Input stage: normalise polarity, register, and keep the previous
  // cycle's copy for change detection.
  logic [6:0] w_seg_norm;
  logic [7:0] w_ans_norm;
  logic [6:0] r_seg, r_seg_prev;
  logic [7:0] r_ans, r_ans_prev;

  assign w_seg_norm = (SEG_ACT_LOW != 0) ? ~bus.seg : bus.seg;
  assign w_ans_norm = (AN_ACT_LOW  != 0) ? ~bus.ans : bus.ans;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_seg      <= 7'h00;
      r_ans      <= 8'h00;
      r_seg_prev <= 7'h00;
      r_ans_prev <= 8'h00;
    end else begin
      r_seg      <= w_seg_norm;
      r_ans      <= w_ans_norm;
      r_seg_prev <= r_seg;
      r_ans_prev <= r_ans;
    end
  end

  logic       w_changed, w_ans_changed, w_onehot;
  logic [2:0] w_idx;

  assign w_changed     = (r_seg != r_seg_prev) || (r_ans != r_ans_prev);
  assign w_ans_changed = (r_ans != r_ans_prev);
  assign w_onehot      = is_onehot(r_ans);
  assign w_idx         = onehot_idx(r_ans);

  // Settle FSM
  state_t     r_state, w_state_next;
  logic [7:0] r_settle_cnt, w_settle_cnt_next;
  logic       w_sample;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= 8'd0;
    end else begin
      r_state      <= w_state_next;
      r_settle_cnt <= w_settle_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_settle_cnt_next = r_settle_cnt;
    w_sample          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_state_next      = S_SETTLE;
          w_settle_cnt_next = 8'd1;
        end
      end
      S_SETTLE: begin
        if (w_changed) begin
          w_settle_cnt_next = 8'd1;
          if (!w_onehot) w_state_next = S_IDLE;
        end else if (r_settle_cnt >= 8'(SETTLE_CYC)) begin
          w_sample     = 1'b1;
          w_state_next = S_HOLD;
        end else begin
          w_settle_cnt_next = r_settle_cnt + 8'd1;
        end
      end
      S_HOLD: begin
        // seg changes are ignored here: one sample per enable period
        if (w_ans_changed) begin
          w_settle_cnt_next = 8'd1;
          w_state_next      = w_onehot ? S_SETTLE : S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Decode of the currently sampled digit
  logic       w_dec_ok;
  logic [3:0] w_dec_nib;

  seg7_to_hex u_dec (
    .i_seg (r_seg),
    .o_ok  (w_dec_ok),
    .o_nib (w_dec_nib)
  );

  logic w_sample_ok, w_sample_bad;
  assign w_sample_ok  = w_sample &&  w_dec_ok;
  assign w_sample_bad = w_sample && !w_dec_ok;

  // Nibble storage and frame assembly
  logic [3:0]  r_nib [8];
  logic [31:0] w_assembled;

  for (genvar gi = 0; gi < 8; gi++) begin : g_asm
    assign w_assembled[gi*4 +: 4] = r_nib[gi];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) r_nib[i] <= 4'h0;
    end else if (w_sample_ok) begin
      r_nib[w_idx] <= w_dec_nib;
    end
  end

  // Frame bookkeeping
  logic [7:0]      r_captured;
  logic [31:0]     r_value;
  logic            r_value_vld, r_frame_err, r_stale;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_hit, w_complete, w_timeout;
  logic [7:0]      w_bit;

  assign w_bit      = 8'h01 << w_idx;
  assign w_to_hit   = (r_to_cnt == TO_W'(TIMEOUT_CYC));
  // Completion is detected on the registered mask, so value/value_vld
  // appear one edge after the last digit is captured.
  assign w_complete = (r_captured == 8'hFF);
  assign w_timeout  = w_to_hit && !w_sample;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_captured  <= 8'h00;
      r_value     <= 32'h0;
      r_value_vld <= 1'b0;
      r_frame_err <= 1'b0;
      r_stale     <= 1'b0;
      r_to_cnt    <= '0;
    end else begin
      r_value_vld <= 1'b0;

      // Timeout counter saturates at the limit until the next sample.
      if (w_sample)       r_to_cnt <= '0;
      else if (!w_to_hit) r_to_cnt <= r_to_cnt + TO_W'(1);

      if (w_complete) begin
        r_value     <= w_assembled;
        r_value_vld <= 1'b1;
        r_captured  <= w_sample_ok ? w_bit : 8'h00;
        r_stale     <= 1'b0;
        r_frame_err <= w_sample_bad;
      end else if (w_timeout) begin
        r_captured <= 8'h00;
        r_stale    <= 1'b1;
      end else begin
        if (w_sample_ok)  r_captured  <= r_captured | w_bit;
        if (w_sample_bad) r_frame_err <= 1'b1;
      end
    end
  end

  assign bus.value     = r_value;
  assign bus.value_vld = r_value_vld;
  assign bus.frame_err = r_frame_err;
  assign bus.stale     = r_stale;

endmodule
